// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory answering CPU load/store
// requests over valid/ready, with programmable wait states.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we/addr/wdata/be     store flag, byte address, data, byte enables
//   resp_valid/resp_ready    response handshake
//   resp_rdata/resp_err      load data (0 for stores/errors), error flag
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW =
    (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int unsigned WAIT_LOAD =
    (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [31:2]   woff;
  logic [AW-1:0] idx;
  logic          acc_err;
  logic          accept;

  assign accept = (state_q == S_IDLE) && req_valid;

  // Word offset from the base; a wrapped subtraction for addresses
  // below the base is caught by the explicit compare.
  assign woff = 30'((addr_q - BASE_ADDR) >> 2);
  assign idx  = woff[AW+1:2];

  assign acc_err = (addr_q[1:0] != 2'b00)
                || (addr_q < BASE_ADDR)
                || ({2'b00, woff} >= DEPTH_WORDS);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  // Datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) cnt_d = CW'(WAIT_LOAD);
      end
      S_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      S_ACCESS: begin
        err_d   = acc_err;
        rdata_d = (acc_err || we_q) ? '0 : mem_q[idx];
      end
      S_RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture; inputs are ignored once accepted.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Store commits on the edge leaving ACCESS; reset there cancels it.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_ACCESS && we_q && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: random and directed traffic
// checked against an array model of the memory.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned W     = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(W),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_be(req_be),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mm [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rr_hold = 0;
  bit          rr_rand = 0;
  bit          seen = 0;
  bit          hs_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed semantics evaluated with plain arithmetic.
  function automatic void ref_model(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rd,
    output logic        e
  );
    longint off;
    int     k;
    off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
    e   = (addr % 4 != 0) || (off < 0) || (off / 4 >= DEPTH);
    rd  = '0;
    if (!e) begin
      k = int'(off / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mm[k][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rd = mm[k];
      end
    end
  endfunction

  // Response side: backpressure hold or random/high ready.
  always @(posedge clk) begin
    #2;
    if (rr_hold > 0) begin
      resp_ready = 1'b0;
      if (resp_valid) rr_hold--;
    end else begin
      resp_ready = rr_rand ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (hs_prev) begin
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_valid", 32'(resp_valid), 32'd0);
        chk("idle_rdata", resp_rdata, 32'd0);
        hs_prev = 0;
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc), 32'(q[0].acc + W + 1));
            seen = 1;
          end
          chk("rdata", resp_rdata, q[0].rdata);
          chk("err", 32'(resp_err), 32'(q[0].err));
          chk("ready_in_resp", 32'(req_ready), 32'd0);
          if (resp_ready) begin
            void'(q.pop_front());
            seen    = 0;
            hs_prev = 1;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input bit push);
    logic [31:0] rd;
    logic        e;
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    if (push) begin
      ref_model(we, addr, wdata, be, rd, e);
      q.push_back('{rd, e, cyc + 1});
    end
    @(negedge clk); #1;
  endtask

  // Drives junk on req_* while busy to prove it is ignored.
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      req_valid = 1'($urandom % 2);
      req_we    = 1'($urandom % 2);
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_be    = 4'($urandom);
      @(negedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    req_valid = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    issue(we, addr, wdata, be, 1);
    wait_done();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom % 10;
    if (r < 7)
      return BASE + 4 * $urandom_range(0, DEPTH - 1);
    else if (r == 7)
      return BASE + 4 * $urandom_range(0, DEPTH - 1)
                  + $urandom_range(1, 3);
    else if (r == 8)
      return BASE + 4 * DEPTH + 4 * $urandom_range(0, 16);
    else
      return BASE - 4 * $urandom_range(1, 16);
  endfunction

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);

    for (int i = 0; i < DEPTH; i++)
      xfer(1, BASE + 4 * i, $urandom, 4'hF);

    xfer(1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
    xfer(0, BASE + 32'h10, 32'h0, 4'h0);

    xfer(1, BASE + 32'h20, 32'h1122_3344, 4'hF);
    xfer(1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101);
    xfer(0, BASE + 32'h20, 32'h0, 4'h0);
    xfer(1, BASE + 32'h20, 32'h5555_5555, 4'h0);
    xfer(0, BASE + 32'h20, 32'h0, 4'h0);

    xfer(0, BASE + 32'h13, 32'h0, 4'h0);
    xfer(1, BASE + 4 * DEPTH, 32'hFFFF_FFFF, 4'hF);
    xfer(0, BASE + 4 * (DEPTH - 1), 32'h0, 4'h0);
    xfer(1, BASE - 4, 32'hFFFF_FFFF, 4'hF);
    xfer(0, BASE - 4, 32'h0, 4'h0);
    xfer(0, 32'hFFFF_FFFC, 32'h0, 4'h0);

    rr_hold = 5;
    xfer(0, BASE + 32'h10, 32'h0, 4'h0);

    xfer(1, BASE + 32'h40, 32'h0, 4'hF);
    issue(1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 0);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_err", 32'(resp_err), 32'd0);
    xfer(0, BASE + 32'h40, 32'h0, 4'h0);

    rr_rand = 1;
    for (int i = 0; i < 200; i++)
      xfer(1'($urandom % 2), rand_addr(), $urandom, 4'($urandom));
    rr_rand = 0;

    for (int i = 0; i < 8; i++)
      xfer(0, BASE + 4 * $urandom_range(0, DEPTH - 1), 32'h0, 4'h0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
